// File: rtl/wieg_regelaar.sv
// Closed-loop cradle motion controller: picks one of 16 speed/amplitude settings,
// judges each after a settle window of clk12 strobes and steps on when stress does not drop.
module wieg_regelaar #(
    parameter int SETTLE_TICKS = 4,
    parameter int MAX_GELIJK   = 3,
    parameter int MAX_POGING   = 8,
    parameter int START_IDX    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk12,
    input  logic       aan,
    input  logic       gedaald,
    input  logic       gelijk,
    output logic [1:0] snelheid,
    output logic [1:0] amplitude,
    output logic       motor_en,
    output logic       wissel,
    output logic       alarm
);

    typedef enum logic [1:0] {
        UIT    = 2'd0,
        WACHT  = 2'd1,
        BESLIS = 2'd2,
        ALARM  = 2'd3
    } state_t;

    localparam logic [3:0] TICK_LAST  = 4'(SETTLE_TICKS - 1);
    localparam logic [2:0] GELIJK_MAX = 3'(MAX_GELIJK);
    localparam logic [3:0] POGING_MAX = 4'(MAX_POGING);
    localparam logic [3:0] IDX_START  = 4'(START_IDX);

    state_t     state;
    logic [3:0] idx;
    logic [3:0] tick_cnt;
    logic [2:0] gelijk_cnt;
    logic [3:0] poging_cnt;
    logic       s_gedaald;
    logic       s_gelijk;

    logic [2:0] gelijk_next;
    logic [3:0] poging_next;
    logic       do_step;

    // gedaald wins over gelijk; a plateau only forces a step once it has lasted MAX_GELIJK windows
    always_comb begin
        gelijk_next = gelijk_cnt + 3'd1;
        poging_next = poging_cnt + 4'd1;
        do_step     = !s_gedaald && (!s_gelijk || (gelijk_next == GELIJK_MAX));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= UIT;
            idx        <= 4'd0;
            tick_cnt   <= 4'd0;
            gelijk_cnt <= 3'd0;
            poging_cnt <= 4'd0;
            s_gedaald  <= 1'b0;
            s_gelijk   <= 1'b0;
            motor_en   <= 1'b0;
            wissel     <= 1'b0;
            alarm      <= 1'b0;
        end else if (!aan) begin
            state      <= UIT;
            idx        <= 4'd0;
            tick_cnt   <= 4'd0;
            gelijk_cnt <= 3'd0;
            poging_cnt <= 4'd0;
            motor_en   <= 1'b0;
            wissel     <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            case (state)
                UIT: begin
                    state      <= WACHT;
                    idx        <= IDX_START;
                    tick_cnt   <= 4'd0;
                    gelijk_cnt <= 3'd0;
                    poging_cnt <= 4'd0;
                    motor_en   <= 1'b1;
                    wissel     <= 1'b0;
                    alarm      <= 1'b0;
                end
                WACHT: begin
                    wissel <= 1'b0;
                    if (clk12) begin
                        if (tick_cnt == TICK_LAST) begin
                            s_gedaald <= gedaald;
                            s_gelijk  <= gelijk;
                            tick_cnt  <= 4'd0;
                            state     <= BESLIS;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                BESLIS: begin
                    if (do_step) begin
                        idx        <= idx + 4'd1;
                        gelijk_cnt <= 3'd0;
                        poging_cnt <= poging_next;
                        wissel     <= 1'b1;
                        if (poging_next == POGING_MAX) begin
                            state <= ALARM;
                            alarm <= 1'b1;
                        end else begin
                            state <= WACHT;
                        end
                    end else if (s_gedaald) begin
                        gelijk_cnt <= 3'd0;
                        poging_cnt <= 4'd0;
                        state      <= WACHT;
                    end else begin
                        gelijk_cnt <= gelijk_next;
                        state      <= WACHT;
                    end
                end
                ALARM: begin
                    // setting frozen until aan drops
                    wissel <= 1'b0;
                end
                default: begin
                    state <= UIT;
                end
            endcase
        end
    end

    assign snelheid  = idx[1:0];
    assign amplitude = idx[3:2];

    a_wissel_single: assert property (@(posedge clk) disable iff (!reset) wissel |=> !wissel);
    a_alarm_motor:   assert property (@(posedge clk) disable iff (!reset) alarm |-> motor_en);
    a_off_idle:      assert property (@(posedge clk) disable iff (!reset)
                                      !motor_en |-> (idx == 4'd0 && !alarm && !wissel));

endmodule

// File: tb/tb_wieg_regelaar.sv
// Bench for wieg_regelaar: two instances (default and a wrap/alarm configuration) share
// stimulus and are compared every cycle against a window-level behavioural model.
module tb_wieg_regelaar;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk12;
    logic       aan;
    logic       gedaald;
    logic       gelijk;
    logic [1:0] a_snelheid, a_amplitude, b_snelheid, b_amplitude;
    logic       a_motor_en, a_wissel, a_alarm;
    logic       b_motor_en, b_wissel, b_alarm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wieg_regelaar dut_a (
        .clk(clk), .reset(reset), .clk12(clk12), .aan(aan),
        .gedaald(gedaald), .gelijk(gelijk),
        .snelheid(a_snelheid), .amplitude(a_amplitude),
        .motor_en(a_motor_en), .wissel(a_wissel), .alarm(a_alarm)
    );

    wieg_regelaar #(
        .SETTLE_TICKS(4), .MAX_GELIJK(2), .MAX_POGING(3), .START_IDX(14)
    ) dut_b (
        .clk(clk), .reset(reset), .clk12(clk12), .aan(aan),
        .gedaald(gedaald), .gelijk(gelijk),
        .snelheid(b_snelheid), .amplitude(b_amplitude),
        .motor_en(b_motor_en), .wissel(b_wissel), .alarm(b_alarm)
    );

    // ---------------- reference model (per instance k: 0 = dut_a, 1 = dut_b)
    localparam int SETTLE = 4;
    int c_gel[2]   = '{3, 2};
    int c_pog[2]   = '{8, 3};
    int c_start[2] = '{5, 14};

    bit m_on[2], m_alarm[2], m_wis[2], m_pend[2], m_pg[2], m_pe[2];
    int m_idx[2], m_tick[2], m_plat[2], m_fail[2];

    task automatic model_clear(input int k);
        m_on[k] = 1'b0; m_alarm[k] = 1'b0; m_wis[k] = 1'b0; m_pend[k] = 1'b0;
        m_idx[k] = 0; m_tick[k] = 0; m_plat[k] = 0; m_fail[k] = 0;
    endtask

    task automatic model_edge(input int k);
        m_wis[k] = 1'b0;
        if (!aan) begin
            model_clear(k);
        end else if (!m_on[k]) begin
            model_clear(k);
            m_on[k]  = 1'b1;
            m_idx[k] = c_start[k];
        end else if (m_alarm[k]) begin
            m_wis[k] = 1'b0;
        end else if (m_pend[k]) begin
            m_pend[k] = 1'b0;
            if (m_pg[k]) begin
                m_plat[k] = 0;
                m_fail[k] = 0;
            end else if (m_pe[k] && (m_plat[k] + 1 < c_gel[k])) begin
                m_plat[k] = m_plat[k] + 1;
            end else begin
                m_idx[k]  = (m_idx[k] + 1) % 16;
                m_plat[k] = 0;
                m_fail[k] = m_fail[k] + 1;
                m_wis[k]  = 1'b1;
                if (m_fail[k] == c_pog[k]) m_alarm[k] = 1'b1;
            end
        end else if (clk12) begin
            m_tick[k] = m_tick[k] + 1;
            if (m_tick[k] == SETTLE) begin
                m_tick[k] = 0;
                m_pend[k] = 1'b1;
                m_pg[k]   = gedaald;
                m_pe[k]   = gelijk;
            end
        end
    endtask

    function automatic logic [13:0] exp_vec();
        return {m_alarm[0], m_wis[0], m_on[0], 4'(m_idx[0]),
                m_alarm[1], m_wis[1], m_on[1], 4'(m_idx[1])};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {a_alarm, a_wissel, a_motor_en, a_amplitude, a_snelheid,
                b_alarm, b_wissel, b_motor_en, b_amplitude, b_snelheid};
    endfunction

    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset) model_clear(k);
            else model_edge(k);
        end
        #1;
    endtask

    // ---------------- stimulus planning
    typedef struct packed {
        logic aan;
        logic c12;
        logic gd;
        logic gl;
    } stim_t;

    stim_t stim_q[$];

    task automatic plan(input int a, input int c, input int g, input int e);
        stim_t s;
        s.aan = a[0]; s.c12 = c[0]; s.gd = g[0]; s.gl = e[0];
        stim_q.push_back(s);
    endtask

    // n strobes with random gaps; only the last one carries the chosen verdict
    task automatic plan_pulses(input int n, input int g, input int e);
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 2)) plan(1, 0, $urandom_range(0, 1), $urandom_range(0, 1));
            if (t == n - 1) plan(1, 1, g, e);
            else plan(1, 1, $urandom_range(0, 1), $urandom_range(0, 1));
        end
    endtask

    // full window, a decision cycle with a stray strobe maybe, then one idle cycle
    task automatic plan_window(input int g, input int e);
        plan_pulses(SETTLE, g, e);
        plan(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        plan(1, 0, 0, 0);
    endtask

    task automatic plan_restart();
        plan(0, 0, 0, 0);
        plan(1, 0, 0, 0);
    endtask

    // ---------------- tests
    task automatic test_reset();
        reset = 1'b0; aan = 1'b0; clk12 = 1'b0; gedaald = 1'b0; gelijk = 1'b0;
        repeat (2) cyc();
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL reset_state: dut=%h want=%h", dut_vec(), 14'd0);
        end
    endtask

    task automatic test_start();
        reset = 1'b1;
        cyc();
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL start_idle: dut=%h model=%h", dut_vec(), exp_vec());
        end
        aan = 1'b1;
        total++;
        if (a_motor_en !== 1'b0) begin
            bad++;
            $display("FAIL start_early: motor_en=%b want=0", a_motor_en);
        end
        cyc();
        total++;
        if ({a_motor_en, a_wissel, a_amplitude, a_snelheid} !== 6'b10_0101) begin
            bad++;
            $display("FAIL start_a: dut=%b want=100101",
                     {a_motor_en, a_wissel, a_amplitude, a_snelheid});
        end
        total++;
        if ({b_motor_en, b_wissel, b_amplitude, b_snelheid} !== 6'b10_1110) begin
            bad++;
            $display("FAIL start_b: dut=%b want=101110",
                     {b_motor_en, b_wissel, b_amplitude, b_snelheid});
        end
        total++;
        if (dut_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL start_model: dut=%h model=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_calm();
        stim_t s;
        int seen = 0;
        plan_restart();
        for (int w = 0; w < 10; w++) plan_window(1, $urandom_range(0, 1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {aan, clk12, gedaald, gelijk} = s;
            cyc();
            if (a_wissel || b_wissel) seen++;
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL calm_cycle: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
        total++;
        if ({a_amplitude, a_snelheid, b_amplitude, b_snelheid} !== 8'h5e) begin
            bad++;
            $display("FAIL calm_idx: dut=%h want=5e",
                     {a_amplitude, a_snelheid, b_amplitude, b_snelheid});
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL calm_wissel: pulses=%0d want=0", seen);
        end
    endtask

    task automatic test_rise_wrap_alarm();
        stim_t s;
        int b_exp[3] = '{15, 0, 1};
        plan_restart();
        for (int w = 0; w < 3; w++) begin
            plan_window(0, 0);
            while (stim_q.size() > 0) begin
                s = stim_q.pop_front();
                {aan, clk12, gedaald, gelijk} = s;
                cyc();
                total++;
                if (dut_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL rise_cycle: dut=%h model=%h", dut_vec(), exp_vec());
                end
            end
            total++;
            if ({a_amplitude, a_snelheid} !== 4'(6 + w) || {b_amplitude, b_snelheid} !== 4'(b_exp[w])) begin
                bad++;
                $display("FAIL rise_idx: a=%0d b=%0d want a=%0d b=%0d",
                         {a_amplitude, a_snelheid}, {b_amplitude, b_snelheid}, 6 + w, b_exp[w]);
            end
        end
        total++;
        if ({a_alarm, b_alarm, b_motor_en} !== 3'b011) begin
            bad++;
            $display("FAIL alarm_set: a_alarm=%b b_alarm=%b b_motor=%b want 0 1 1",
                     a_alarm, b_alarm, b_motor_en);
        end
        plan_window($urandom_range(0, 1), $urandom_range(0, 1));
        plan_window(0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {aan, clk12, gedaald, gelijk} = s;
            cyc();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL alarm_cycle: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
        total++;
        if ({b_alarm, b_motor_en, b_wissel, b_amplitude, b_snelheid} !== 7'b110_0001) begin
            bad++;
            $display("FAIL alarm_frozen: dut=%b want=1100001",
                     {b_alarm, b_motor_en, b_wissel, b_amplitude, b_snelheid});
        end
        aan = 1'b0; clk12 = 1'b0;
        cyc();
        total++;
        if ({b_alarm, b_motor_en, a_motor_en, b_amplitude, b_snelheid} !== 7'd0) begin
            bad++;
            $display("FAIL alarm_exit: dut=%b want=0000000",
                     {b_alarm, b_motor_en, a_motor_en, b_amplitude, b_snelheid});
        end
    endtask

    task automatic test_plateau();
        stim_t s;
        int g_seq[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int e_seq[8] = '{1, 1, 1, 1, 0, 1, 1, 1};
        int a_exp[8] = '{5, 5, 6, 6, 6, 6, 6, 7};
        plan_restart();
        for (int w = 0; w < 8; w++) begin
            plan_window(g_seq[w], e_seq[w]);
            while (stim_q.size() > 0) begin
                s = stim_q.pop_front();
                {aan, clk12, gedaald, gelijk} = s;
                cyc();
                total++;
                if (dut_vec() !== exp_vec()) begin
                    bad++;
                    $display("FAIL plateau_cycle: dut=%h model=%h", dut_vec(), exp_vec());
                end
            end
            total++;
            if ({a_amplitude, a_snelheid} !== 4'(a_exp[w])) begin
                bad++;
                $display("FAIL plateau_idx: window=%0d idx=%0d want=%0d",
                         w, {a_amplitude, a_snelheid}, a_exp[w]);
            end
        end
    endtask

    task automatic test_enable_drop();
        stim_t s;
        plan_restart();
        plan_pulses(2, 0, 0);
        plan_restart();
        plan_pulses(3, 0, 0);
        plan(1, 0, 0, 0);
        plan(1, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {aan, clk12, gedaald, gelijk} = s;
            cyc();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL drop_cycle: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
        total++;
        if ({a_wissel, a_amplitude, a_snelheid} !== 5'b0_0101) begin
            bad++;
            $display("FAIL drop_partial: dut=%b want=00101", {a_wissel, a_amplitude, a_snelheid});
        end
        plan_pulses(1, 0, 0);
        plan(1, 0, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {aan, clk12, gedaald, gelijk} = s;
            cyc();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL drop_cycle: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
        total++;
        if ({a_wissel, a_amplitude, a_snelheid} !== 5'b1_0110) begin
            bad++;
            $display("FAIL drop_full: dut=%b want=10110", {a_wissel, a_amplitude, a_snelheid});
        end
    endtask

    task automatic test_async_reset();
        stim_t s;
        plan_restart();
        plan_pulses(2, 0, 0);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {aan, clk12, gedaald, gelijk} = s;
            cyc();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL areset_cycle: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL areset_immediate: dut=%h want=%h", dut_vec(), 14'd0);
        end
        aan = 1'b0; clk12 = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        total++;
        if (dut_vec() !== 14'd0) begin
            bad++;
            $display("FAIL areset_release: dut=%h want=%h", dut_vec(), 14'd0);
        end
        aan = 1'b1;
        cyc();
        total++;
        if ({a_motor_en, a_wissel, a_amplitude, a_snelheid} !== 6'b10_0101) begin
            bad++;
            $display("FAIL areset_restart: dut=%b want=100101",
                     {a_motor_en, a_wissel, a_amplitude, a_snelheid});
        end
    endtask

    task automatic test_random();
        stim_t s;
        plan_restart();
        for (int w = 0; w < 40; w++) begin
            if ($urandom_range(0, 9) == 0) plan_restart();
            plan_window($urandom_range(0, 1), $urandom_range(0, 1));
        end
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            {aan, clk12, gedaald, gelijk} = s;
            cyc();
            total++;
            if (dut_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_cycle: dut=%h model=%h", dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_calm();
        test_rise_wrap_alarm();
        test_plateau();
        test_enable_drop();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
